// File: rtl/serv_state_pkg.sv
// Shared types and constants for the W-bit-wide SERV state/sequencing block.
package serv_state_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam int CNT_HIT_N   = 7;
  localparam int CNT_HIT_B0  = 0;
  localparam int CNT_HIT_B1  = 1;
  localparam int CNT_HIT_B2  = 2;
  localparam int CNT_HIT_B3  = 3;
  localparam int CNT_HIT_B7  = 4;
  localparam int CNT_HIT_B11 = 5;
  localparam int CNT_HIT_B12 = 6;

  // Bit position watched by each o_cnt_hit index.
  function automatic int hit_pos(input int k);
    case (k)
      CNT_HIT_B0:  return 0;
      CNT_HIT_B1:  return 1;
      CNT_HIT_B2:  return 2;
      CNT_HIT_B3:  return 3;
      CNT_HIT_B7:  return 7;
      CNT_HIT_B11: return 11;
      default:     return 12;
    endcase
  endfunction

  function automatic int beats(input int w);
    return 32 / w;
  endfunction

endpackage

// File: rtl/serv_state_wide_cnt.sv
// Beat counter for a W-bit datapath: bit index, run flag and position decodes.
// Honours i_cnt_stall when SERV_STATE_STALL_EN is defined.
module serv_cnt_w
  import serv_state_pkg::*;
#(
  parameter int W = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
`ifdef SERV_STATE_STALL_EN
  input  logic                 i_cnt_stall,
`endif
  output logic                 o_cnt_en,
  output logic [4:0]           o_cnt,
  output logic                 o_cnt_done,
  output logic [CNT_HIT_N-1:0] o_cnt_hit,
  output logic                 o_cnt0to3,
  output logic                 o_cnt12to31
);

  generate
    if (W != 1 && W != 2 && W != 4 && W != 8) begin : g_bad_w
      $error("serv_cnt_w: W must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam int         NB   = beats(W);
  localparam logic [4:0] STEP = 5'(W);
  localparam logic [4:0] LAST = 5'((NB - 1) * W);

  logic [4:0] r_cnt;
  logic       r_cnt_en;
  logic       w_stall;
  logic       w_adv;

`ifdef SERV_STATE_STALL_EN
  assign w_stall = i_cnt_stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_adv = r_cnt_en & ~w_stall;

  // Counter wraps 32->0 by 5-bit overflow, so it is already 0 for the next stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= 5'd0;
      r_cnt_en <= 1'b0;
    end else if (i_start) begin
      r_cnt_en <= 1'b1;
    end else if (w_adv) begin
      r_cnt <= r_cnt + STEP;
      if (r_cnt == LAST) r_cnt_en <= 1'b0;
    end
  end

  assign o_cnt       = r_cnt;
  assign o_cnt_en    = r_cnt_en;
  assign o_cnt_done  = w_adv & (r_cnt == LAST);
  assign o_cnt0to3   = r_cnt_en & (r_cnt < 5'd4);
  assign o_cnt12to31 = r_cnt_en & (({1'b0, r_cnt} + 6'(W - 1)) >= 6'd12);

  generate
    for (genvar k = 0; k < CNT_HIT_N; k++) begin : g_hit
      localparam int P = hit_pos(k);
      assign o_cnt_hit[k] = w_adv & ({1'b0, r_cnt} <= 6'(P))
                                  & (6'(P) < ({1'b0, r_cnt} + 6'(W)));
    end
  endgenerate

endmodule

// File: rtl/serv_state_wide.sv
// Per-instruction sequencer FETCH -> [INIT] -> HOLD -> RUN for a W-bit datapath.
// Optional SERV_STATE_STALL_EN adds i_cnt_stall to pause counting stages.
module serv_state_wide
  import serv_state_pkg::*;
#(
  parameter int W        = 1,
  parameter bit WITH_CSR = 1'b1,
  parameter bit ALIGN    = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ibus_ack,
  output logic       o_ibus_cyc,
  output logic       o_rf_rreq,
  output logic       o_rf_wreq,
  input  logic       i_rf_ready,
  input  logic       i_two_stage_op,
  input  logic       i_branch_op,
  input  logic       i_cond_branch,
  input  logic       i_bne_or_bge,
  input  logic       i_dbus_en,
  input  logic       i_e_op,
  input  logic       i_alu_cmp,
  input  logic       i_ctrl_misalign,
  input  logic       i_mem_misalign,
  input  logic       i_new_irq,
`ifdef SERV_STATE_STALL_EN
  input  logic       i_cnt_stall,
`endif
  output logic       o_dbus_cyc,
  input  logic       i_dbus_ack,
  output logic       o_init,
  output logic       o_cnt_en,
  output logic [4:0] o_cnt,
  output logic       o_cnt_done,
  output logic [6:0] o_cnt_hit,
  output logic       o_cnt0to3,
  output logic       o_cnt12to31,
  output logic [1:0] o_mem_bytecnt,
  output logic       o_ctrl_pc_en,
  output logic       o_ctrl_jump,
  output logic       o_ctrl_trap,
  output logic       o_bufreg_en
);

  state_t r_state;
  logic   r_ibus_cyc, r_jump, r_trap, r_hold_first, r_dbus_done;
  logic   w_idle, w_hold, w_start, w_adv, w_take, w_trap_set, w_dbus_act, w_trap;

  assign w_idle  = (r_state == IDLE);
  assign w_hold  = (r_state == HOLD);
  assign w_start = i_rf_ready & (w_idle | w_hold) & ~o_cnt_en;

  serv_cnt_w #(.W(W)) u_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (w_start),
`ifdef SERV_STATE_STALL_EN
    .i_cnt_stall (i_cnt_stall),
`endif
    .o_cnt_en    (o_cnt_en),
    .o_cnt       (o_cnt),
    .o_cnt_done  (o_cnt_done),
    .o_cnt_hit   (o_cnt_hit),
    .o_cnt0to3   (o_cnt0to3),
    .o_cnt12to31 (o_cnt12to31)
  );

`ifdef SERV_STATE_STALL_EN
  assign w_adv = o_cnt_en & ~i_cnt_stall;
`else
  assign w_adv = o_cnt_en;
`endif

  assign w_take     = i_branch_op & (~i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));
  assign w_trap_set = WITH_CSR & ((w_take & i_ctrl_misalign & ~ALIGN) |
                                  (i_dbus_en & i_mem_misalign));
  assign w_dbus_act = w_hold & ~r_trap & i_dbus_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_ibus_cyc   <= 1'b1;
      r_jump       <= 1'b0;
      r_trap       <= 1'b0;
      r_hold_first <= 1'b0;
      r_dbus_done  <= 1'b0;
    end else begin
      r_hold_first <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_ibus_ack) begin
            r_ibus_cyc <= 1'b0;
            r_jump     <= 1'b0;
            r_trap     <= 1'b0;
          end
          // A pending irq skips INIT so the trap runs straight away.
          if (w_start) r_state <= (i_two_stage_op & ~i_new_irq) ? INIT : RUN;
        end
        INIT: if (o_cnt_done) begin
          r_jump       <= w_take;
          r_trap       <= w_trap_set;
          r_hold_first <= 1'b1;
          r_dbus_done  <= 1'b0;
          r_state      <= HOLD;
        end
        HOLD: begin
          if (w_dbus_act & i_dbus_ack) r_dbus_done <= 1'b1;
          if (w_start) r_state <= RUN;
        end
        RUN: if (o_cnt_done) begin
          r_ibus_cyc <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_trap        = WITH_CSR & (i_e_op | i_new_irq | r_trap);
  assign o_ctrl_trap   = w_trap;
  assign o_ibus_cyc    = r_ibus_cyc & i_rst_n;
  assign o_rf_rreq     = (w_idle & i_ibus_ack) | (w_hold & r_hold_first & r_trap);
  assign o_rf_wreq     = w_hold & ~r_trap &
                         ((r_hold_first & ~i_dbus_en) | (i_dbus_en & i_dbus_ack & ~r_dbus_done));
  assign o_dbus_cyc    = w_dbus_act & ~r_dbus_done;
  assign o_init        = (r_state == INIT);
  assign o_ctrl_pc_en  = (r_state == RUN) & w_adv;
  assign o_bufreg_en   = (o_init & w_adv) |
                         ((r_state == RUN) & w_adv & i_two_stage_op & (w_trap | i_branch_op));
  assign o_ctrl_jump   = r_jump;
  assign o_mem_bytecnt = o_cnt[4:3];

endmodule

// File: tb/tb_serv_state_wide.sv
// Scoreboard bench: scripted instruction transactions push per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_serv_state_wide;

  localparam int TW     = 4;
  localparam bit TCSR   = 1'b1;
  localparam bit TALIGN = 1'b0;
  localparam int NB     = 32 / TW;
`ifdef SERV_STATE_STALL_EN
  localparam bit HAS_STALL = 1'b1;
`else
  localparam bit HAS_STALL = 1'b0;
`endif

  bit clk = 1'b1;
  always #5 clk = ~clk;

  logic rst_n, ibus_ack, rf_ready, two, br, cond, bneg, dben, eop, cmp, cmis, mmis, irq;
  logic dbus_ack, stall;
  logic o_ibus_cyc, o_rf_rreq, o_rf_wreq, o_dbus_cyc, o_init, o_cnt_en, o_cnt_done;
  logic o_cnt0to3, o_cnt12to31, o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap, o_bufreg_en;
  logic [4:0] o_cnt;
  logic [6:0] o_cnt_hit;
  logic [1:0] o_mem_bytecnt;

  serv_state_wide #(.W(TW), .WITH_CSR(TCSR), .ALIGN(TALIGN)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ibus_ack(ibus_ack), .o_ibus_cyc(o_ibus_cyc),
    .o_rf_rreq(o_rf_rreq), .o_rf_wreq(o_rf_wreq), .i_rf_ready(rf_ready),
    .i_two_stage_op(two), .i_branch_op(br), .i_cond_branch(cond), .i_bne_or_bge(bneg),
    .i_dbus_en(dben), .i_e_op(eop), .i_alu_cmp(cmp), .i_ctrl_misalign(cmis),
    .i_mem_misalign(mmis), .i_new_irq(irq),
`ifdef SERV_STATE_STALL_EN
    .i_cnt_stall(stall),
`endif
    .o_dbus_cyc(o_dbus_cyc), .i_dbus_ack(dbus_ack), .o_init(o_init), .o_cnt_en(o_cnt_en),
    .o_cnt(o_cnt), .o_cnt_done(o_cnt_done), .o_cnt_hit(o_cnt_hit), .o_cnt0to3(o_cnt0to3),
    .o_cnt12to31(o_cnt12to31), .o_mem_bytecnt(o_mem_bytecnt), .o_ctrl_pc_en(o_ctrl_pc_en),
    .o_ctrl_jump(o_ctrl_jump), .o_ctrl_trap(o_ctrl_trap), .o_bufreg_en(o_bufreg_en)
  );

  typedef struct packed {
    logic ibus, rreq, wreq, dbus, init, pc_en, jump, trap, bufreg;
  } ctl_t;
  typedef struct packed {
    logic en; logic [4:0] cnt; logic done; logic [6:0] hit; logic c03, c12; logic [1:0] bc;
  } cnt_t;
  typedef struct packed { ctl_t c; cnt_t n; } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   m_ibus, m_jump, m_trap;
  int   POS[7] = '{0, 1, 2, 3, 7, 11, 12};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      ctl_t gc;
      cnt_t gn;
      e  = q.pop_front();
      gc = {o_ibus_cyc, o_rf_rreq, o_rf_wreq, o_dbus_cyc, o_init, o_ctrl_pc_en,
            o_ctrl_jump, o_ctrl_trap, o_bufreg_en};
      gn = {o_cnt_en, o_cnt, o_cnt_done, o_cnt_hit, o_cnt0to3, o_cnt12to31, o_mem_bytecnt};
      checks++;
      if (gc !== e.c) begin
        errors++;
        $display("FAIL ctl t=%0t got=%b want=%b (ibus rreq wreq dbus init pc jump trap bufreg)",
                 $time, gc, e.c);
      end
      checks++;
      if (gn !== e.n) begin
        errors++;
        $display("FAIL cnt t=%0t got=%b want=%b (en cnt done hit c03 c12 bytecnt)",
                 $time, gn, e.n);
      end
    end
  end

  function automatic exp_t base();
    exp_t e;
    e        = '0;
    e.c.ibus = m_ibus;
    e.c.jump = m_jump;
    e.c.trap = TCSR & (eop | irq | m_trap);
    return e;
  endfunction

  task automatic cyc(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
    ibus_ack = 1'b0; rf_ready = 1'b0; dbus_ack = 1'b0; stall = 1'b0;
  endtask

  // Non-counting cycle with noise on inputs that must have no effect here.
  task automatic idle_cyc();
    dbus_ack = ($urandom_range(0, 3) == 0);
    stall    = 1'($urandom_range(0, 1));
    cyc(base());
  endtask

  task automatic count_stage(input bit is_init, input int abort_b);
    int b;
    b = 0;
    while (b < NB) begin
      exp_t e;
      bit   st;
      int   c;
      stall    = HAS_STALL && (b != abort_b) && ($urandom_range(0, 3) == 0);
      rf_ready = ($urandom_range(0, 3) == 0);
      dbus_ack = ($urandom_range(0, 3) == 0);
      st = stall;
      c  = b * TW;
      e  = base();
      if (!is_init && b == abort_b) begin
        rst_n    = 1'b0;
        e.c.ibus = 1'b0;
        e.c.jump = 1'b0;
        e.c.trap = TCSR & (eop | irq);
        cyc(e);
        rst_n  = 1'b1;
        m_ibus = 1'b1; m_jump = 1'b0; m_trap = 1'b0;
        return;
      end
      e.n.en   = 1'b1;
      e.n.cnt  = 5'(c);
      e.n.done = (b == NB - 1) && !st;
      for (int k = 0; k < 7; k++) e.n.hit[k] = !st && (c <= POS[k]) && (POS[k] < c + TW);
      e.n.c03  = (c < 4);
      e.n.c12  = (c + TW - 1 >= 12);
      e.n.bc   = e.n.cnt[4:3];
      if (is_init) begin
        e.c.init   = 1'b1;
        e.c.bufreg = !st;
      end else begin
        e.c.pc_en  = !st;
        e.c.bufreg = !st && two && (e.c.trap || br);
      end
      cyc(e);
      if (!st) b++;
    end
    if (is_init) begin
      bit take;
      take   = br && (!cond || (cmp ^ bneg));
      m_jump = take;
      m_trap = TCSR && ((take && cmis && !TALIGN) || (dben && mmis));
    end else begin
      m_ibus = 1'b1;
    end
  endtask

  task automatic hold_phase(input int ack_delay);
    int ack_at, rdy_at;
    bit act, acked;
    act    = !m_trap && dben;
    acked  = 1'b0;
    ack_at = act ? ((ack_delay >= 0) ? ack_delay : int'($urandom_range(1, 5))) : -1;
    rdy_at = (act ? ack_at : 0) + int'($urandom_range(0, 2));
    for (int h = 0; h <= rdy_at; h++) begin
      exp_t e;
      stall    = 1'($urandom_range(0, 1));
      dbus_ack = (h == ack_at);
      rf_ready = (h == rdy_at);
      e        = base();
      e.c.rreq = m_trap && (h == 0);
      e.c.dbus = act && !acked;
      e.c.wreq = (!m_trap && !dben && h == 0) || (act && h == ack_at);
      cyc(e);
      if (h == ack_at) acked = 1'b1;
    end
  endtask

  task automatic instr(input bit t_two, t_br, t_cond, t_bneg, t_cmp, t_cmis, t_dben, t_mmis,
                       input bit t_irq, t_eop, input int ack_delay, input int abort_b);
    exp_t e;
    bit   ar;
    two = t_two; br = t_br; cond = t_cond; bneg = t_bneg; cmp = t_cmp;
    cmis = t_cmis; dben = t_dben; mmis = t_mmis; irq = t_irq; eop = t_eop;
    repeat ($urandom_range(0, 2)) idle_cyc();
    ibus_ack = 1'b1;
    rf_ready = 1'($urandom_range(0, 1));
    ar       = rf_ready;
    e        = base();
    e.c.rreq = 1'b1;
    cyc(e);
    m_ibus = 1'b0; m_jump = 1'b0; m_trap = 1'b0;
    if (!ar) begin
      repeat ($urandom_range(0, 2)) idle_cyc();
      rf_ready = 1'b1;
      cyc(base());
    end
    if (t_two && !t_irq) begin
      count_stage(1'b1, -1);
      hold_phase(ack_delay);
    end
    count_stage(1'b0, abort_b);
  endtask

  initial begin
    rst_n = 1'b0; ibus_ack = 1'b0; rf_ready = 1'b0; dbus_ack = 1'b0; stall = 1'b0;
    two = 1'b0; br = 1'b0; cond = 1'b0; bneg = 1'b0; dben = 1'b0; eop = 1'b0;
    cmp = 1'b0; cmis = 1'b0; mmis = 1'b0; irq = 1'b0;
    m_ibus = 1'b0; m_jump = 1'b0; m_trap = 1'b0;
    repeat (2) cyc(base());
    rst_n  = 1'b1;
    m_ibus = 1'b1;

    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1);      // plain single-stage op
    instr(1, 1, 1, 0, 1, 1, 0, 0, 0, 0, -1, -1);      // taken beq, misaligned target
    instr(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5, -1);       // load, ack after 5 cycles
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 16 / TW); // reset at o_cnt=16
    instr(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, -1, -1);      // irq skips INIT
    instr(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, -1, -1);      // misaligned store traps
    instr(1, 1, 1, 1, 1, 1, 0, 0, 0, 1, -1, -1);      // not-taken bne, ebreak
    repeat (40) begin
      instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), -1,
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NB - 1)) : -1);
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
